// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN sequencer.
// Optional stall/flush statistics counters are compiled in with IF_STALL_STATS_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCwrite,
    input  logic        IFIDwrite,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        dbg_state
`ifdef IF_STALL_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} seq_state_t;

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    // Redirect targets are word aligned, so the low two target bits are dropped.
    logic unused_ok;
    assign unused_ok = &{1'b0, branch_target[1:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // ifid_valid qualifies ifid_instr/ifid_pc4: 1 = real fetched instruction, 0 = bubble.
    // There is no back-pressure; PCwrite and IFIDwrite are independent load enables.
    always_comb begin
        state_d      = S_RUN;
        pc_plus4     = pc_q + 32'd4;
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (flush) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (PCwrite) begin
            pc_d = pc_plus4;
        end

        if (flush) begin
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (IFIDwrite) begin
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = instr_in;
            // The first fetch after reset is not trusted as a real instruction.
            ifid_valid_d = (state_q == S_RUN);
        end
    end

    assign pc_out     = pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign dbg_state  = (state_q == S_RUN);

`ifdef IF_STALL_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (state_q == S_RUN && !PCwrite && !flush && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage (RESET_PC=0x40): vector table plus hand-written stall/saturation sequences.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        PCwrite;
    logic        IFIDwrite;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        dbg_state;
`ifdef IF_STALL_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .PCwrite       (PCwrite),
        .IFIDwrite     (IFIDwrite),
        .flush         (flush),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .dbg_state     (dbg_state)
`ifdef IF_STALL_STATS_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic [31:0] bt;
        logic [31:0] instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_run;
        logic [15:0] e_stall;
        logic [15:0] e_flush;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic rst_n, input logic pcw, input logic ifw, input logic fl,
                         input logic [31:0] bt, input logic [31:0] instr);
        reset_n       = rst_n;
        PCwrite       = pcw;
        IFIDwrite     = ifw;
        flush         = fl;
        branch_target = bt;
        instr_in      = instr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic rst_n, logic pcw, logic ifw, logic fl, logic [31:0] bt,
                                logic [31:0] instr, logic [31:0] e_pc, logic [31:0] e_pc4,
                                logic [31:0] e_instr, logic e_valid, logic e_run,
                                logic [15:0] e_stall, logic [15:0] e_flush);
        vec_t v;
        v.rst_n = rst_n; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.bt = bt; v.instr = instr;
        v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_valid = e_valid;
        v.e_run = e_run; v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        //            rst pcw ifw fl  bt            instr         pc            pc4           instr         v  run stall flush
        vecs[0]  = mk(0, 1, 1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0,        32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 32'h0,         32'hA000_0001, 32'h0000_0044, 32'h0000_0044, 32'hA000_0001, 0, 1, 0, 0);
        vecs[2]  = mk(1, 1, 1, 0, 32'h0,         32'hA000_0002, 32'h0000_0048, 32'h0000_0048, 32'hA000_0002, 1, 1, 0, 0);
        vecs[3]  = mk(1, 1, 1, 0, 32'h0,         32'hA000_0003, 32'h0000_004C, 32'h0000_004C, 32'hA000_0003, 1, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 32'h0,         32'hB000_0000, 32'h0000_004C, 32'h0000_004C, 32'hA000_0003, 1, 1, 1, 0);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,         32'hB000_0001, 32'h0000_0050, 32'h0000_004C, 32'hA000_0003, 1, 1, 1, 0);
        vecs[6]  = mk(1, 0, 1, 0, 32'h0,         32'hB000_0002, 32'h0000_0050, 32'h0000_0054, 32'hB000_0002, 1, 1, 2, 0);
        vecs[7]  = mk(1, 0, 0, 1, 32'h0000_2003, 32'hB000_0003, 32'h0000_2000, 32'h0,        32'h0,        0, 1, 2, 1);
        vecs[8]  = mk(1, 1, 1, 0, 32'h0,         32'hC000_0000, 32'h0000_2004, 32'h0000_2004, 32'hC000_0000, 1, 1, 2, 1);
        vecs[9]  = mk(1, 1, 1, 1, 32'hFFFF_FFFE, 32'hC000_0001, 32'hFFFF_FFFC, 32'h0,        32'h0,        0, 1, 2, 2);
        vecs[10] = mk(1, 1, 1, 0, 32'h0,         32'hD000_0000, 32'h0000_0000, 32'h0000_0000, 32'hD000_0000, 1, 1, 2, 2);
        vecs[11] = mk(1, 1, 1, 0, 32'h0,         32'hD000_0001, 32'h0000_0004, 32'h0000_0004, 32'hD000_0001, 1, 1, 2, 2);
        vecs[12] = mk(0, 0, 0, 1, 32'h0000_3000, 32'hD000_0002, 32'h0000_0040, 32'h0,        32'h0,        0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 1, 32'h0000_0500, 32'hE000_0000, 32'h0000_0500, 32'h0,        32'h0,        0, 1, 0, 1);
        vecs[14] = mk(1, 1, 1, 0, 32'h0,         32'hE000_0001, 32'h0000_0504, 32'h0000_0504, 32'hE000_0001, 1, 1, 0, 1);
        vecs[15] = mk(0, 1, 1, 0, 32'h0,         32'hE000_0002, 32'h0000_0040, 32'h0,        32'h0,        0, 0, 0, 0);
        vecs[16] = mk(1, 1, 0, 0, 32'h0,         32'hF000_0000, 32'h0000_0044, 32'h0,        32'h0,        0, 1, 0, 0);
        vecs[17] = mk(1, 1, 1, 0, 32'h0,         32'hF000_0001, 32'h0000_0048, 32'h0000_0048, 32'hF000_0001, 1, 1, 0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst_n, vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].bt, vecs[i].instr);
            step();
            check($sformatf("v%0d pc_out", i),     pc_out,             vecs[i].e_pc);
            check($sformatf("v%0d ifid_pc4", i),   ifid_pc4,           vecs[i].e_pc4);
            check($sformatf("v%0d ifid_instr", i), ifid_instr,         vecs[i].e_instr);
            check($sformatf("v%0d ifid_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d state", i),      {31'h0, dbg_state},  {31'h0, vecs[i].e_run});
`ifdef IF_STALL_STATS_EN
            check($sformatf("v%0d stall_cnt", i),  {16'h0, stall_cnt},  {16'h0, vecs[i].e_stall});
            check($sformatf("v%0d flush_cnt", i),  {16'h0, flush_cnt},  {16'h0, vecs[i].e_flush});
`endif
        end

        // Hold at pc 0x100 for two cycles with both enables low.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00FC, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0000);
        step();
        check("run pc_out", pc_out, 32'h0000_0100);
        check("run ifid_instr", ifid_instr, 32'h1111_0000);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2222_0000 + i);
            step();
            check($sformatf("stall%0d pc_out", i), pc_out, 32'h0000_0100);
            check($sformatf("stall%0d ifid_pc4", i), ifid_pc4, 32'h0000_0100);
            check($sformatf("stall%0d ifid_instr", i), ifid_instr, 32'h1111_0000);
            check($sformatf("stall%0d ifid_valid", i), {31'h0, ifid_valid}, 32'h1);
        end
`ifdef IF_STALL_STATS_EN
        check("stall2 stall_cnt", {16'h0, stall_cnt}, 32'h2);
        check("stall2 flush_cnt", {16'h0, flush_cnt}, 32'h1);
        // Push the stall counter well past its 16-bit range.
        for (int i = 0; i < 65538; i++) step();
        check("sat stall_cnt", {16'h0, stall_cnt}, 32'h0000_FFFF);
        check("sat pc_out", pc_out, 32'h0000_0100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
